// File: rtl/master_ctrl_pkg.sv
// master_ctrl_pkg: shared types and helpers for the master control path.
//   state_t      - sequencing FSM states
//   nl_tbl_t     - latched per-layer neuron counts (entry k = layer k)
//   nl_sel       - select a layer's neuron count by index
//   nl_eff       - neuron count with 0 promoted to 1
//   clamp_layers - layer count limited to MAX_LAYERS
package master_ctrl_pkg;

  localparam int unsigned MAX_LAYERS = 5;
  localparam int unsigned IDX_W      = 6;

  typedef enum logic [3:0] {
    IDLE,
    LOAD_B,
    LOAD_W,
    COMPUTE,
    ACCUM,
    SHIFT,
    ACTIVATE,
    WRITE,
    DONE
  } state_t;

  typedef logic [MAX_LAYERS-1:0][IDX_W-1:0] nl_tbl_t;

  function automatic logic [IDX_W-1:0] nl_sel(input nl_tbl_t tbl,
                                              input logic [IDX_W-1:0] idx);
    case (idx)
      6'd0:    nl_sel = tbl[0];
      6'd1:    nl_sel = tbl[1];
      6'd2:    nl_sel = tbl[2];
      6'd3:    nl_sel = tbl[3];
      default: nl_sel = tbl[4];
    endcase
  endfunction

  function automatic logic [IDX_W-1:0] nl_eff(input logic [IDX_W-1:0] v);
    nl_eff = (v == '0) ? IDX_W'(1) : v;
  endfunction

  function automatic logic [IDX_W-1:0] clamp_layers(input logic [IDX_W-1:0] v);
    clamp_layers = (v > IDX_W'(MAX_LAYERS)) ? IDX_W'(MAX_LAYERS) : v;
  endfunction

endpackage

// File: rtl/master_control_path_phase_counter.sv
// phase_counter: loadable down-counter with terminal-count flag.
//   clk, reset   - clock, asynchronous active-high reset
//   load         - load load_val on the next edge (overrides counting)
//   load_val     - value to load (phase length minus one)
//   tc           - high while the count is zero; the count rests at zero
module phase_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == '0);

endmodule

// File: rtl/master_control_path.sv
// master_control_path: layer-serial sequencing FSM for the NN engine.
// Walks layers 0..no_layers-1 and every input of each layer, driving the
// load/compute/accumulate/activate/write strobes of the compute bank.
//   clk, reset     - clock, asynchronous active-high reset
//   start          - run request, sampled in IDLE
//   no_layers      - layer count (0 -> straight to DONE, >5 clamped to 5)
//   nl1..nl5       - neuron counts of layers 0..4 (0 treated as 1)
//   weight_en, bias_en, bias_sign, compute_en, af_en,
//   out_shft_en, out_wr_en, output_sig - datapath strobes
//   tot_complete   - network finished (held in DONE)
//   n, i           - current layer / input index
//   busy           - only with MCP_BUSY_OUT_EN defined: run in progress
module master_control_path
  import master_ctrl_pkg::*;
#(
  parameter int unsigned NUM_IN0        = 3,
  parameter int unsigned COMPUTE_CYCLES = 16,
  parameter int unsigned AF_CYCLES      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [IDX_W-1:0] no_layers,
  input  logic [IDX_W-1:0] nl1,
  input  logic [IDX_W-1:0] nl2,
  input  logic [IDX_W-1:0] nl3,
  input  logic [IDX_W-1:0] nl4,
  input  logic [IDX_W-1:0] nl5,
  output logic             weight_en,
  output logic             bias_en,
  output logic             compute_en,
  output logic             af_en,
  output logic             out_shft_en,
  output logic             out_wr_en,
  output logic             output_sig,
  output logic             bias_sign,
  output logic             tot_complete,
  output logic [IDX_W-1:0] n,
  output logic [IDX_W-1:0] i
`ifdef MCP_BUSY_OUT_EN
  ,
  output logic             busy
`endif
);

  localparam int unsigned CNT_W = $clog2(COMPUTE_CYCLES + AF_CYCLES + (1 << IDX_W));
  localparam logic [CNT_W-1:0] COMP_LD = CNT_W'(COMPUTE_CYCLES - 1);
  localparam logic [CNT_W-1:0] AF_LD   = CNT_W'(AF_CYCLES - 1);
  localparam logic [IDX_W-1:0] IN0     = IDX_W'(NUM_IN0);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] n_q, n_d, i_q, i_d;
  logic [IDX_W-1:0] nlay_q, nlay_d;
  nl_tbl_t          nl_q, nl_d;
  logic             osig_q, osig_d;

  logic             cnt_load;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_tc;

  logic [IDX_W-1:0] nl_cur, nl_nxt, in_cur, start_layers;
  nl_tbl_t          start_tbl;
  logic             last_in, last_layer;

  phase_counter #(.W(CNT_W)) u_phase_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .tc       (cnt_tc)
  );

  // Layer geometry from the latched table; inputs of layer n>0 = NL of n-1.
  always_comb begin
    nl_cur       = nl_sel(nl_q, n_q);
    nl_nxt       = nl_sel(nl_q, n_q + IDX_W'(1));
    in_cur       = (n_q == '0) ? IN0 : nl_sel(nl_q, n_q - IDX_W'(1));
    last_in      = (i_q == in_cur - IDX_W'(1));
    last_layer   = (n_q == nlay_q - IDX_W'(1));
    start_tbl    = {nl_eff(nl5), nl_eff(nl4), nl_eff(nl3), nl_eff(nl2), nl_eff(nl1)};
    start_layers = clamp_layers(no_layers);
  end

  // The phase counter is loaded on the edge that enters a timed phase,
  // so tc marks the last cycle of that phase.
  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    i_d      = i_q;
    nlay_d   = nlay_q;
    nl_d     = nl_q;
    osig_d   = osig_q;
    cnt_load = 1'b0;
    cnt_val  = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          nl_d   = start_tbl;
          nlay_d = start_layers;
          n_d    = '0;
          i_d    = '0;
          osig_d = 1'b0;
          if (start_layers == '0) begin
            state_d = DONE;
          end else begin
            state_d  = LOAD_B;
            cnt_load = 1'b1;
            cnt_val  = CNT_W'(start_tbl[0]) - CNT_W'(1);
          end
        end
      end
      LOAD_B: begin
        if (cnt_tc) begin
          state_d  = LOAD_W;
          cnt_load = 1'b1;
          cnt_val  = CNT_W'(nl_cur) - CNT_W'(1);
        end
      end
      LOAD_W: begin
        if (cnt_tc) begin
          state_d  = COMPUTE;
          cnt_load = 1'b1;
          cnt_val  = COMP_LD;
        end
      end
      COMPUTE: begin
        if (cnt_tc) state_d = ACCUM;
      end
      ACCUM: state_d = SHIFT;
      SHIFT: begin
        cnt_load = 1'b1;
        if (last_in) begin
          state_d = ACTIVATE;
          cnt_val = AF_LD;
        end else begin
          state_d = LOAD_W;
          i_d     = i_q + IDX_W'(1);
          cnt_val = CNT_W'(nl_cur) - CNT_W'(1);
        end
      end
      ACTIVATE: begin
        if (cnt_tc) state_d = WRITE;
      end
      WRITE: begin
        if (last_layer) begin
          state_d = DONE;
        end else begin
          state_d  = LOAD_B;
          n_d      = n_q + IDX_W'(1);
          i_d      = '0;
          osig_d   = 1'b1;
          cnt_load = 1'b1;
          cnt_val  = CNT_W'(nl_nxt) - CNT_W'(1);
        end
      end
      DONE: begin
        // Indices and output_sig are cleared on the way out so IDLE shows all zeros.
        if (!start) begin
          state_d = IDLE;
          n_d     = '0;
          i_d     = '0;
          osig_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      n_q     <= '0;
      i_q     <= '0;
      nlay_q  <= '0;
      nl_q    <= '0;
      osig_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      i_q     <= i_d;
      nlay_q  <= nlay_d;
      nl_q    <= nl_d;
      osig_q  <= osig_d;
    end
  end

  // Strobes are decoded from the state register only, so they are glitch-free
  // and mutually exclusive by construction.
  always_comb begin
    weight_en    = 1'b0;
    bias_en      = 1'b0;
    compute_en   = 1'b0;
    af_en        = 1'b0;
    out_shft_en  = 1'b0;
    out_wr_en    = 1'b0;
    bias_sign    = 1'b0;
    tot_complete = 1'b0;
    case (state_q)
      LOAD_B:   bias_en = 1'b1;
      LOAD_W:   weight_en = 1'b1;
      COMPUTE:  compute_en = 1'b1;
      ACCUM: begin
        compute_en = 1'b1;
        bias_en    = 1'b1;
        bias_sign  = 1'b1;
      end
      SHIFT:    out_shft_en = osig_q;
      ACTIVATE: begin
        compute_en = 1'b1;
        af_en      = 1'b1;
      end
      WRITE:    out_wr_en = 1'b1;
      DONE:     tot_complete = 1'b1;
      default:  ;
    endcase
  end

  assign output_sig = osig_q;
  assign n          = n_q;
  assign i          = i_q;

`ifdef MCP_BUSY_OUT_EN
  assign busy = (state_q != IDLE) && (state_q != DONE);
`endif

endmodule

// File: tb/tb_master_control_path.sv
module tb_master_control_path;

  localparam int NUM_IN0 = 3;
  localparam int CC      = 16;
  localparam int AF      = 16;

  logic       clk = 1'b0;
  logic       reset, start;
  logic [5:0] no_layers, nl1, nl2, nl3, nl4, nl5;
  logic       weight_en, bias_en, compute_en, af_en, out_shft_en, out_wr_en;
  logic       output_sig, bias_sign, tot_complete;
  logic [5:0] n, i;
`ifdef MCP_BUSY_OUT_EN
  logic       busy;
`endif

  master_control_path #(
    .NUM_IN0        (NUM_IN0),
    .COMPUTE_CYCLES (CC),
    .AF_CYCLES      (AF)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .no_layers    (no_layers),
    .nl1          (nl1),
    .nl2          (nl2),
    .nl3          (nl3),
    .nl4          (nl4),
    .nl5          (nl5),
    .weight_en    (weight_en),
    .bias_en      (bias_en),
    .compute_en   (compute_en),
    .af_en        (af_en),
    .out_shft_en  (out_shft_en),
    .out_wr_en    (out_wr_en),
    .output_sig   (output_sig),
    .bias_sign    (bias_sign),
    .tot_complete (tot_complete),
    .n            (n),
    .i            (i)
`ifdef MCP_BUSY_OUT_EN
    ,
    .busy         (busy)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [20:0] all_outs();
    return {weight_en, bias_en, compute_en, af_en, out_shft_en, out_wr_en,
            output_sig, bias_sign, tot_complete, n, i};
  endfunction

  // Reference: totals derived from the per-layer rules (geometry and phase lengths).
  task automatic model(input int nlay, input int a, input int b, input int c,
                       input int d, input int e,
                       output int cyc, output int w, output int bi, output int sh,
                       output int wr, output int cmp, output int af, output int fn);
    int nl[5];
    int L, prev, k_nl, k_in;
    nl = '{a, b, c, d, e};
    L = (nlay > 5) ? 5 : nlay;
    cyc = 0; w = 0; bi = 0; sh = 0; wr = 0; cmp = 0; af = 0; prev = 0;
    for (int k = 0; k < L; k++) begin
      k_nl = (nl[k] == 0) ? 1 : nl[k];
      k_in = (k == 0) ? NUM_IN0 : prev;
      cyc += k_nl + k_in * (k_nl + CC + 2) + AF + 1;
      w   += k_in * k_nl;
      bi  += k_nl + k_in;
      if (k > 0) sh += k_in;
      wr  += 1;
      cmp += k_in * (CC + 1) + AF;
      af  += AF;
      prev = k_nl;
    end
    fn = (L == 0) ? 0 : L - 1;
  endtask

  // One full run: start is sampled on one edge and then dropped.
  // cyc = number of edges after the start-sampling edge before DONE is seen.
  task automatic run_net(input int nlay, input int a, input int b, input int c,
                         input int d, input int e,
                         output int cyc, output int w, output int bi, output int sh,
                         output int wr, output int cmp, output int af, output int inv,
                         output int fn, output int to);
    int cnt;
    cyc = 0; w = 0; bi = 0; sh = 0; wr = 0; cmp = 0; af = 0; inv = 0; fn = 0; to = 0;
    @(negedge clk);
    no_layers = nlay[5:0];
    nl1 = a[5:0]; nl2 = b[5:0]; nl3 = c[5:0]; nl4 = d[5:0]; nl5 = e[5:0];
    start = 1'b1;
    @(posedge clk);
    for (cnt = 0; cnt < 5000; cnt++) begin
      @(negedge clk);
      start = 1'b0;
      if ((int'(weight_en) + int'(bias_en) + int'(out_shft_en) + int'(out_wr_en)) > 1) inv++;
      if (output_sig != (n != 0)) inv++;
      if (out_shft_en && !output_sig) inv++;
      if (tot_complete) begin
        fn = int'(n);
        break;
      end
      w   += int'(weight_en);
      bi  += int'(bias_en);
      sh  += int'(out_shft_en);
      wr  += int'(out_wr_en);
      cmp += int'(compute_en);
      af  += int'(af_en);
      cyc++;
    end
    if (cnt >= 5000) to = 1;
    for (cnt = 0; cnt < 10 && tot_complete; cnt++) @(negedge clk);
    if (tot_complete) to = 1;
  endtask

  typedef struct {
    int nlay;
    int n0, n1, n2, n3, n4;
    int cyc, w, b, sh, wr;
  } vec_t;

  initial begin
    vec_t tbl[6];
    int cyc, w, bi, sh, wr, cmp, af, inv, fn, to;
    int ecyc, ew, ebi, esh, ewr, ecmp, eaf, efn;
    int r[6];
    int cnt;

    tbl[0] = '{1, 2, 0, 0, 0, 0,  79,  6,  5, 0, 1};
    tbl[1] = '{2, 3, 2, 0, 0, 0, 162, 15, 11, 3, 2};
    tbl[2] = '{0, 4, 4, 4, 4, 4,   0,  0,  0, 0, 0};
    tbl[3] = '{1, 0, 0, 0, 0, 0,  75,  3,  4, 0, 1};
    tbl[4] = '{7, 1, 1, 1, 1, 1, 223,  7, 12, 4, 5};
    tbl[5] = '{3, 4, 1, 2, 0, 0, 220, 18, 15, 5, 3};

    reset = 1'b1; start = 1'b0; no_layers = '0;
    nl1 = '0; nl2 = '0; nl3 = '0; nl4 = '0; nl5 = '0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", int'(all_outs()), 0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_outputs", int'(all_outs()), 0);

    foreach (tbl[k]) begin
      run_net(tbl[k].nlay, tbl[k].n0, tbl[k].n1, tbl[k].n2, tbl[k].n3, tbl[k].n4,
              cyc, w, bi, sh, wr, cmp, af, inv, fn, to);
      chk($sformatf("vec%0d_timeout", k), to, 0);
      chk($sformatf("vec%0d_latency", k), cyc, tbl[k].cyc);
      chk($sformatf("vec%0d_weight_en", k), w, tbl[k].w);
      chk($sformatf("vec%0d_bias_en", k), bi, tbl[k].b);
      chk($sformatf("vec%0d_out_shft_en", k), sh, tbl[k].sh);
      chk($sformatf("vec%0d_out_wr_en", k), wr, tbl[k].wr);
      chk($sformatf("vec%0d_invariants", k), inv, 0);
    end

    // Random networks against the reference model.
    for (int t = 0; t < 20; t++) begin
      int nlay;
      nlay = int'($urandom_range(0, 7));
      foreach (r[k]) r[k] = int'($urandom_range(0, 6));
      model(nlay, r[0], r[1], r[2], r[3], r[4], ecyc, ew, ebi, esh, ewr, ecmp, eaf, efn);
      run_net(nlay, r[0], r[1], r[2], r[3], r[4], cyc, w, bi, sh, wr, cmp, af, inv, fn, to);
      chk($sformatf("rnd%0d_timeout", t), to, 0);
      chk($sformatf("rnd%0d_latency", t), cyc, ecyc);
      chk($sformatf("rnd%0d_weight_en", t), w, ew);
      chk($sformatf("rnd%0d_bias_en", t), bi, ebi);
      chk($sformatf("rnd%0d_out_shft_en", t), sh, esh);
      chk($sformatf("rnd%0d_out_wr_en", t), wr, ewr);
      chk($sformatf("rnd%0d_compute_en", t), cmp, ecmp);
      chk($sformatf("rnd%0d_af_en", t), af, eaf);
      chk($sformatf("rnd%0d_final_n", t), fn, efn);
      chk($sformatf("rnd%0d_invariants", t), inv, 0);
    end

    // Asynchronous reset in the middle of LOAD_W, then a clean restart.
    @(negedge clk);
    no_layers = 6'd1; nl1 = 6'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (cnt = 0; cnt < 100 && !weight_en; cnt++) @(negedge clk);
    chk("mid_reset_reached_load_w", int'(weight_en), 1);
    #2 reset = 1'b1;
    #1 chk("mid_reset_async_clear", int'(all_outs()), 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("post_reset_idle", int'(all_outs()), 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("restart_bias_en", int'(bias_en), 1);
    chk("restart_weight_en", int'(weight_en), 0);
    chk("restart_n", int'(n), 0);
    chk("restart_i", int'(i), 0);
    for (cnt = 0; cnt < 200 && !tot_complete; cnt++) @(negedge clk);
    chk("restart_completes", int'(tot_complete), 1);
    @(negedge clk);

    // Start held high through DONE: no restart until it drops.
    no_layers = 6'd1; nl1 = 6'd1;
    start = 1'b1;
    for (cnt = 0; cnt < 200 && !tot_complete; cnt++) @(negedge clk);
    chk("hold_reaches_done", int'(tot_complete), 1);
    repeat (5) @(negedge clk);
    chk("hold_stays_done", int'(tot_complete), 1);
    chk("hold_no_strobes", int'({weight_en, bias_en, compute_en, out_wr_en}), 0);
    start = 1'b0;
    @(negedge clk);
    chk("hold_release_idle", int'(tot_complete), 0);
    chk("hold_release_outputs", int'(all_outs()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/master_control_path.md
# master_control_path

Sequencing FSM for the layer-serial neural-network engine. It walks layers 0..no_layers-1 and, within each layer, every input. It drives the load, compute, accumulate, activate and write strobes for the 64-lane bank of `recon_top_level` compute units and their weight, bias and output banks. It reports the current layer `n` and input index `i`, which the datapath uses for mux selection.

## Interface
Parameters:
- `NUM_IN0`, default 3: number of inputs consumed by layer 0.
- `COMPUTE_CYCLES`, default 16: MAC latency of `recon_top_level` (CORDIC iterations).
- `AF_CYCLES`, default 16: activation-function latency of `recon_top_level`.

Ports:
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high.
- `start` input 1: run request, level-sampled in IDLE.
- `no_layers` input 6: layer count, legal range 1..5.
- `nl1`..`nl5` input 6 each: neuron count of layers 0..4.
- `weight_en` output 1: shift one weight into the weight bank.
- `bias_en` output 1: bias-bank write enable.
- `compute_en` output 1: compute units run; the datapath derives unit reset as its inverse.
- `af_en` output 1: activation-function phase.
- `out_shft_en` output 1: shift the output bank down one entry.
- `out_wr_en` output 1: capture `compute_out` into the output bank.
- `output_sig` output 1: 0 = the datapath uses external inputs, 1 = it uses `output_bank[0]`.
- `bias_sign` output 1: with `bias_en`, 0 = shift in `bias_in`, 1 = load `mac_output` (accumulate).
- `tot_complete` output 1: network finished.
- `n` output 6: current layer index.
- `i` output 6: current input index within the layer.

## Operation
- Layer neuron count `NL = {nl1..nl5}[n]`; a value of 0 is treated as 1.
- Layer input count is `NUM_IN0` for n = 0, otherwise the previous layer's `NL`.
- `no_layers` and all `nl*` are latched when `start` is accepted.
- `no_layers` = 0 goes directly to DONE; values above 5 are clamped to 5.

States:
- IDLE: all outputs 0. If `start` = 1, set n = 0, i = 0, go to LOAD_B.
- LOAD_B: `bias_en` = 1, `bias_sign` = 0 for NL cycles, then LOAD_W.
- LOAD_W: `weight_en` = 1 for NL cycles, then COMPUTE.
- COMPUTE: `compute_en` = 1 for `COMPUTE_CYCLES` cycles, then ACCUM.
- ACCUM: `compute_en` = 1, `bias_en` = 1, `bias_sign` = 1 for 1 cycle (partial sum fed back as bias), then SHIFT.
- SHIFT: 1 cycle; `out_shft_en` = `output_sig`. If i = inputs-1, go to ACTIVATE; else i++ and go to LOAD_W.
- ACTIVATE: `compute_en` = 1, `af_en` = 1 for `AF_CYCLES` cycles, then WRITE.
- WRITE: `out_wr_en` = 1 for 1 cycle. If n = no_layers-1, go to DONE; else n++, i = 0, `output_sig` = 1, go to LOAD_B.
- DONE: `tot_complete` = 1; n and i hold. Return to IDLE when `start` = 0.

Other rules:
- `output_sig` is 0 throughout layer 0 and 1 throughout every later layer. It is cleared in IDLE.
- `start` is ignored outside IDLE.
- Every strobe is a registered, decoded function of state, so at most one of `weight_en`, `bias_en`, `out_shft_en`, `out_wr_en` is high in any cycle.

## Timing
- Reset (asynchronous, any state): state = IDLE, n = i = 0, all outputs 0, counters cleared. The next run begins from IDLE.
- The first LOAD_B cycle is the cycle after `start` is sampled high in IDLE.
- Per-layer cycle count: NL + inputs·(NL + COMPUTE_CYCLES + 2) + AF_CYCLES + 1.
- `tot_complete` rises on the cycle after the final WRITE.
- `n` and `i` change only on state-transition edges. They are stable during every strobe that depends on them.

## Configuration
- `MCP_BUSY_OUT_EN` defined: adds output `busy` (1 bit). It is high from the first LOAD_B cycle until DONE is entered, 0 at reset.
- Macro undefined: the `busy` port does not exist; all other behaviour is identical.

## Structure
- Package `master_ctrl_pkg`:
  - state enum (IDLE, LOAD_B, LOAD_W, COMPUTE, ACCUM, SHIFT, ACTIVATE, WRITE, DONE)
  - `MAX_LAYERS` = 5
  - `IDX_W` = 6
- Sub-module `phase_counter`: a loadable down-counter with a terminal-count flag. One instance serves all timed phases.

## Test plan
- Reset mid-LOAD_W: assert `reset` asynchronously → all outputs 0 in the same cycle; after release and `start`, the run restarts at LOAD_B with n = 0.
- no_layers = 1, nl1 = 2, NUM_IN0 = 3, COMPUTE_CYCLES = 16, AF_CYCLES = 16 → `tot_complete` rises 79 cycles after the first LOAD_B cycle. Check: `weight_en` high 6 cycles total, `bias_en` high 2+3 cycles, `output_sig` = 0, `out_shft_en` never high.
- no_layers = 2, nl1 = 3, nl2 = 2 → layer 1 runs 3 inputs with `output_sig` = 1, 3 `out_shft_en` pulses and 2 `out_wr_en` pulses total; n steps 0 → 1.
- no_layers = 0 → DONE one cycle after `start`; no strobe is ever asserted.
- Hold `start` high through DONE → `tot_complete` stays 1 with no restart. Drop `start` → IDLE, `tot_complete` = 0.
- nl1 = 0 → behaves as nl1 = 1 (single `weight_en` pulse per input).
